// File: rtl/data_mem_ctrl.sv
// Byte-addressed, byte-enabled RV32I data memory with valid/ready request/response handshake.
// Optional macro DATA_MEM_MISALIGN_ERR_EN: flag misaligned halfword/word accesses instead of force-aligning them.
module data_mem_ctrl #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [2:0]  LAT_M1    = 3'(READ_LATENCY - 1);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("data_mem_ctrl: DATA_WIDTH must be 32");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("data_mem_ctrl: READ_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [2:0]                r_cnt;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;
    logic [31:0]               r_mem [MEM_DEPTH];

    logic                      w_req_ready;
    logic                      w_rsp_valid;
    logic                      w_accept;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic [1:0]                w_off;
    logic [1:0]                w_lane_off;
    logic                      w_illegal;
    logic                      w_misalign;
    logic                      w_err;
    logic [3:0]                w_be;
    logic [31:0]               w_wdata_lanes;
    logic [31:0]               w_rd_word;
    logic [31:0]               w_shifted;
    logic [31:0]               w_load_data;
    logic                      w_unused_addr;

    assign w_idx         = req_addr[MEM_DEPTH_LOG2+1:2];
    assign w_off         = req_addr[1:0];
    assign w_unused_addr = ^req_addr[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2+2];
    assign w_accept      = req_valid & w_req_ready;

    // Loads: 011/110/111 illegal; stores: anything above SW illegal.
    always_comb begin
        if (req_we) begin
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3[2] & req_funct3[1]);
        end
    end

`ifdef DATA_MEM_MISALIGN_ERR_EN
    always_comb begin
        w_misalign = ((req_funct3[1:0] == 2'b01) & w_off[0]) |
                     ((req_funct3[1:0] == 2'b10) & (w_off != 2'b00));
        w_lane_off = w_off;
    end
`else
    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_lane_off = {w_off[1], 1'b0};
            2'b10:   w_lane_off = 2'b00;
            default: w_lane_off = w_off;
        endcase
    end
`endif

    assign w_err = w_illegal | w_misalign;

    always_comb begin
        w_be          = '0;
        w_wdata_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00:   w_wdata_lanes = {4{req_wdata[7:0]}};
            2'b01:   w_wdata_lanes = {2{req_wdata[15:0]}};
            default: w_wdata_lanes = req_wdata;
        endcase
        if (req_we && !w_err) begin
            case (req_funct3[1:0])
                2'b00:   w_be = 4'b0001 << w_lane_off;
                2'b01:   w_be = 4'b0011 << w_lane_off;
                2'b10:   w_be = '1;
                default: w_be = '0;
            endcase
        end
    end

    // Array is read combinationally and the extended result captured on the accept edge.
    assign w_rd_word = r_mem[w_idx];
    assign w_shifted = w_rd_word >> {w_lane_off, 3'b000};

    always_comb begin
        w_load_data = '0;
        if (!req_we && !w_err) begin
            case (req_funct3)
                3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
                3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
                3'b010:  w_load_data = w_shifted;
                3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
                3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
                default: w_load_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_load_data;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= LAT_M1;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_req_ready = 1'b1;
            ST_RESP: w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_mem_ctrl;

    localparam int unsigned LAT        = 4;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned MEM_BYTES  = 4 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0]  m_mem [MEM_BYTES];
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    logic        exp_er;

    data_mem_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH_LOG2(DEPTH_LOG2),
        .READ_LATENCY  (LAT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: access size from funct3, little-endian bytes, aliasing modulo memory size.
    function automatic void model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er);
        int unsigned size;
        int unsigned ba;
        logic        legal;
        logic        mis;
        logic [31:0] val;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        ba    = addr % MEM_BYTES;
        mis   = (ba % size) != 0;
`ifdef DATA_MEM_MISALIGN_ERR_EN
        o_er = !legal || mis;
`else
        o_er = !legal;
        ba   = ba - (ba % size);
`endif
        o_rd = '0;
        if (!o_er) begin
            if (we) begin
                for (int unsigned i = 0; i < size; i++) m_mem[ba+i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int unsigned i = 0; i < size; i++) val = val | (32'(m_mem[ba+i]) << (8*i));
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                o_rd = val;
            end
        end
    endfunction

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int unsigned bp,
                        output logic [31:0] o_rd, output logic o_er);
        logic [31:0] e_rd;
        logic        e_er;
        int unsigned cyc;
        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        model_op(we, f3, addr, wd, e_rd, e_er);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!rsp_valid) check_eq("req_ready_wait", 32'(req_ready), 32'd0);
        end while (!rsp_valid && cyc < LAT + 4);
        check_eq("latency", cyc, LAT);
        check_eq("rsp_rdata", rsp_rdata, e_rd);
        check_eq("rsp_err", 32'(rsp_err), 32'(e_er));
        o_rd = rsp_rdata;
        o_er = rsp_err;
        repeat (bp) begin
            @(negedge clk);
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_ready", 32'(req_ready), 32'd0);
            check_eq("bp_rdata", rsp_rdata, e_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 64; i++) xact(1'b1, 3'b010, 32'(i * 4), $urandom, 0, rd, er);

        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check_eq("sw_err", 32'(er), 32'd0);
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
        check_eq("lb_13", rd, 32'hFFFFFFDE);
        xact(1'b0, 3'b100, 32'h13, 32'h0, 1, rd, er);
        check_eq("lbu_13", rd, 32'h000000DE);
        xact(1'b0, 3'b001, 32'h12, 32'h0, 0, rd, er);
        check_eq("lh_12", rd, 32'hFFFFDEAD);
        xact(1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er);
        check_eq("lhu_10", rd, 32'h0000BEEF);
        check_eq("lhu_err", 32'(er), 32'd0);

        xact(1'b1, 3'b010, 32'h20, 32'h11223344, 0, rd, er);
        xact(1'b1, 3'b000, 32'h21, 32'h000000AA, 0, rd, er);
        xact(1'b1, 3'b001, 32'h22, 32'h00005566, 0, rd, er);
        xact(1'b0, 3'b010, 32'h20, 32'h0, 3, rd, er);
        check_eq("byte_en_lw", rd, 32'h5566AA44);

        xact(1'b1, 3'b010, 32'h1004, 32'hCAFEF00D, 0, rd, er);
        xact(1'b0, 3'b010, 32'h0004, 32'h0, 0, rd, er);
        check_eq("wrap_lw", rd, 32'hCAFEF00D);

        xact(1'b1, 3'b010, 32'h30, 32'h12345678, 0, rd, er);
        xact(1'b0, 3'b011, 32'h30, 32'h0, 0, rd, er);
        check_eq("ill_ld_err", 32'(er), 32'd1);
        check_eq("ill_ld_rdata", rd, 32'd0);
        xact(1'b1, 3'b100, 32'h30, 32'hFFFFFFFF, 0, rd, er);
        check_eq("ill_st_err", 32'(er), 32'd1);
        xact(1'b1, 3'b001, 32'h31, 32'h0000BEEF, 0, rd, er);
`ifdef DATA_MEM_MISALIGN_ERR_EN
        check_eq("mis_sh_err", 32'(er), 32'd1);
        xact(1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er);
        check_eq("mis_sh_lw", rd, 32'h12345678);
`else
        check_eq("mis_sh_err", 32'(er), 32'd0);
        xact(1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er);
        check_eq("mis_sh_lw", rd, 32'h1234BEEF);
`endif

        // Reset mid-WAIT after a store: response dropped, store already committed.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h0BADF00D;
        model_op(1'b1, 3'b010, 32'h40, 32'h0BADF00D, exp_rd, exp_er);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("async_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            check_eq("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        xact(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er);
        check_eq("rst_store_kept", rd, 32'h0BADF00D);

        for (int unsigned n = 0; n < 300; n++) begin
            xact(1'($urandom), 3'($urandom),
                 ($urandom & 32'hFFFF_F000) | 32'(($urandom % 64) << 2) | 32'($urandom % 4),
                 $urandom, $urandom % 3, rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
